multicycle_control_unit: RTL and testbench

- Control FSM for the multicycle MIPS datapath, the successor to the single-cycle combinational decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the shared-ALU, IR, PC and register-file enables.
- Adds a memory-ready handshake, jump support, a full R-type funct decode and sticky illegal-opcode detection.

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/alu_decoder.sv | 33 +++
 rtl/multicycle_control_unit.sv | 162 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// ALU control codes, datapath mux selects and the FSM state enum.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ      = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode: fixed add/sub from the FSM, or the
// R-type funct field, with a flag marking unsupported functs.
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  logic [5:0]           funct,
  input  aluop_t               aluop,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 funct_valid
);

  always_comb begin
    alu_control = ALUCTRL_W'(ALU_ADD);
    funct_valid = 1'b1;
    case (aluop)
      ALUOP_SUB: alu_control = ALUCTRL_W'(ALU_SUB);
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALUCTRL_W'(ALU_ADD);
          FN_SUB:  alu_control = ALUCTRL_W'(ALU_SUB);
          FN_AND:  alu_control = ALUCTRL_W'(ALU_AND);
          FN_OR:   alu_control = ALUCTRL_W'(ALU_OR);
          FN_SLT:  alu_control = ALUCTRL_W'(ALU_SLT);
          default: funct_valid = 1'b0;
        endcase
      end
      default: alu_control = ALUCTRL_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and records unsupported instructions.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W   = 4,
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int STATE_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic [ALUCTRL_W-1:0] ALUcontrol,
  output logic                 illegal,
  output logic [STATE_W-1:0]   state
);

  state_t                 state_q, state_d;
  logic                   illegal_q, illegal_set;
  aluop_t                 aluop;
  logic                   funct_valid;
  logic [ALUCTRL_W-1:0]   dec_control;
  logic                   rdy;

  // Memory handshake: a request (MemRead/MemWrite) is held steady until a
  // clock edge where mem_ready is high; that edge completes the access.
  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decoder (
    .funct       (Funct),
    .aluop       (aluop),
    .alu_control (dec_control),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    aluop       = ALUOP_ADD;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    PCSrc       = PCSRC_ALU;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (rdy) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        ALUSrcB = SRCB_IMM_SH;
        case (Opcode)
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d     = S_FETCH;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_RTYPE_EX: begin
        ALUSrcA     = 1'b1;
        aluop       = ALUOP_FUNCT;
        illegal_set = !funct_valid;
        state_d     = funct_valid ? S_RTYPE_WB : S_FETCH;
      end
      S_RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        PCWrite = zero;
        state_d = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCWrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IDLE drives an all-zero ALUcontrol rather than the add default.
  assign ALUcontrol = (state_q == S_IDLE) ? '0 : dec_control;
  assign illegal    = illegal_q;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: an instruction-level model
// expands each instruction into its expected per-cycle control vectors.
module tb_multicycle_control_unit;
  import mips_ctrl_pkg::*;

  localparam int W = 22;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Opcode = '0;
  logic [5:0] Funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic       RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUcontrol, state;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  logic         zero_q[$];
  logic         ill_m = 1'b0;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUcontrol(ALUcontrol),
    .illegal(illegal), .state(state)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] obs();
    return {state, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
            RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUcontrol, illegal};
  endfunction

  function automatic logic [W-2:0] ctl(input state_t s, input logic pcw, iord, mr, mw,
                                       irw, m2r, rdst, rw, srca,
                                       input logic [1:0] srcb, pcsrc,
                                       input logic [3:0] aluc);
    return {s, pcw, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, pcsrc, aluc};
  endfunction

  // R-type funct table: {supported, ALU code}
  function automatic logic [4:0] funct_code(input logic [5:0] fn);
    case (fn)
      6'b100000: return {1'b1, 4'b0010};
      6'b100010: return {1'b1, 4'b0110};
      6'b100100: return {1'b1, 4'b0000};
      6'b100101: return {1'b1, 4'b0001};
      6'b101010: return {1'b1, 4'b0111};
      default:   return {1'b0, 4'b0010};
    endcase
  endfunction

  task automatic push(input logic [W-2:0] v, input logic r, input logic z);
    exp_q.push_back({v, ill_m});
    rdy_q.push_back(r);
    zero_q.push_back(z);
  endtask

  // Reference model: expand one instruction into its cycle-by-cycle controls.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fetch_wait, input int mem_wait);
    logic [4:0] fc;
    for (int i = 0; i < fetch_wait; i++)
      push(ctl(S_FETCH, 0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 4'b0010), 1'b0, 1'($urandom));
    push(ctl(S_FETCH, 1,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 4'b0010), 1'b1, 1'($urandom));
    push(ctl(S_DECODE, 0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 4'b0010), 1'($urandom), 1'($urandom));
    case (op)
      6'b100011: begin
        push(ctl(S_MEMADR, 0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0010), 1'($urandom), 1'($urandom));
        for (int i = 0; i < mem_wait; i++)
          push(ctl(S_MEMRD, 0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 4'b0010), 1'b0, 1'($urandom));
        push(ctl(S_MEMRD, 0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 4'b0010), 1'b1, 1'($urandom));
        push(ctl(S_MEMWB, 0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 4'b0010), 1'($urandom), 1'($urandom));
      end
      6'b101011: begin
        push(ctl(S_MEMADR, 0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0010), 1'($urandom), 1'($urandom));
        for (int i = 0; i < mem_wait; i++)
          push(ctl(S_MEMWR, 0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 4'b0010), 1'b0, 1'($urandom));
        push(ctl(S_MEMWR, 0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 4'b0010), 1'b1, 1'($urandom));
      end
      6'b000000: begin
        fc = funct_code(fn);
        push(ctl(S_RTYPE_EX, 0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, fc[3:0]), 1'($urandom), 1'($urandom));
        if (fc[4])
          push(ctl(S_RTYPE_WB, 0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 4'b0010), 1'($urandom), 1'($urandom));
        else
          ill_m = 1'b1;
      end
      6'b000100:
        push(ctl(S_BEQ, z,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 4'b0110), 1'($urandom), z);
      6'b001000: begin
        push(ctl(S_ADDI_EX, 0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0010), 1'($urandom), 1'($urandom));
        push(ctl(S_ADDI_WB, 0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 4'b0010), 1'($urandom), 1'($urandom));
      end
      6'b000010:
        push(ctl(S_JUMP, 1,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 4'b0010), 1'($urandom), 1'($urandom));
      default: ill_m = 1'b1;
    endcase
  endtask

  task automatic hold_reset_and_release();
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", obs(), '0);
    end
    rst_n = 1'b1;
    ill_m = 1'b0;
    #1 check("idle_after_reset", obs(), '0);
  endtask

  // Driver: play the queued cycles; abort_at >= 0 asserts reset mid-cycle.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int abort_at);
    logic [W-1:0] e;
    int idx = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      if (idx == 0) begin
        Opcode = op;
        Funct  = fn;
      end
      mem_ready = rdy_q.pop_front();
      zero      = zero_q.pop_front();
      e         = exp_q.pop_front();
      if (idx == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check("async_reset", obs(), '0);
        exp_q.delete();
        rdy_q.delete();
        zero_q.delete();
        hold_reset_and_release();
        return;
      end
      @(negedge clk);
      check($sformatf("op%02h_fn%02h_cyc%0d", op, fn, idx), obs(), e);
      idx++;
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw, input int abort_at);
    build(op, fn, z, fw, mw);
    run(op, fn, abort_at);
  endtask

  initial begin
    int k, fw, mw, ab;
    logic [5:0] op, fn;
    logic [5:0] valid_fn[5];
    valid_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    rst_n = 1'b0;
    #3 check("reset_state", obs(), '0);
    hold_reset_and_release();

    instr(OP_LW, 6'h00, 1'b0, 0, 0, -1);
    instr(OP_SW, 6'h00, 1'b0, 0, 3, -1);
    instr(OP_RTYPE, 6'b101010, 1'b0, 0, 0, -1);
    instr(OP_RTYPE, 6'b000111, 1'b0, 0, 0, -1);
    instr(OP_BEQ, 6'h00, 1'b1, 0, 0, -1);
    instr(OP_BEQ, 6'h00, 1'b0, 1, 0, -1);
    instr(OP_J, 6'h00, 1'b0, 0, 0, -1);
    instr(6'b111111, 6'h00, 1'b0, 0, 0, -1);
    instr(OP_ADDI, 6'h00, 1'b0, 0, 0, -1);
    instr(OP_LW, 6'h00, 1'b0, 2, 2, -1);
    // sw aborted in its second MEMWR wait cycle
    instr(OP_SW, 6'h00, 1'b0, 0, 3, 4);
    instr(OP_ADDI, 6'h00, 1'b0, 0, 0, -1);

    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 8);
      case (k)
        0: op = OP_LW;
        1: op = OP_SW;
        2, 3: op = OP_RTYPE;
        4: op = OP_BEQ;
        5: op = OP_ADDI;
        6: op = OP_J;
        default: op = 6'($urandom_range(0, 63));
      endcase
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                       : valid_fn[$urandom_range(0, 4)];
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      build(op, fn, 1'($urandom), fw, mw);
      ab = ($urandom_range(0, 14) == 0) ? $urandom_range(0, exp_q.size() - 1) : -1;
      run(op, fn, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
